// File: rtl/wd_mfm_pkg.sv
// Shared definitions for the MFM sync detector: FSM state encoding and default byte values.
package wd_mfm_pkg;

    typedef enum logic [1:0] {
        StHunt = 2'd0,
        StGap  = 2'd1,
        StLock = 2'd2
    } wd_state_e;

    localparam logic [7:0] GapByteDefault  = 8'h4E;
    localparam logic [7:0] MarkByteDefault = 8'hA1;

endpackage

// File: rtl/wd_byte_match.sv
// Purely combinational WIDTH-bit equality compare of a byte against a constant pattern.
module wd_byte_match #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] pattern_i,
    output logic             match_o
);

    assign match_o = (data_i == pattern_i);

endmodule

// File: rtl/wd_sync_detector.sv
// MFM sync detector: locks on a run of gap bytes and flags a following address mark.
// Mark detection is built only when WD_SYNC_MARK_EN is defined; otherwise mark_found is 0.
module wd_sync_detector
    import wd_mfm_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] GAP_VAL  = WIDTH'(GapByteDefault),
    parameter logic [WIDTH-1:0] MARK_VAL = WIDTH'(MarkByteDefault),
    parameter int unsigned      MIN_GAP  = 4,
    parameter int unsigned      CNT_W    = 6
) (
    input  logic             clk_50,
    input  logic             reset_n,
    input  logic             byte_valid,
    input  logic [WIDTH-1:0] byte_buffer,
    output logic             gap_seen,
    output logic             locked,
    output logic             mark_found,
    output logic [CNT_W-1:0] gap_count
);

    localparam logic [CNT_W-1:0] MinGapCnt = CNT_W'(MIN_GAP);
    localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};

    wd_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             gap_seen_q, gap_seen_d;
    logic             locked_q, locked_d;
    logic             is_gap;

    wd_byte_match #(
        .WIDTH (WIDTH)
    ) u_gap_match (
        .data_i    (byte_buffer),
        .pattern_i (GAP_VAL),
        .match_o   (is_gap)
    );

`ifdef WD_SYNC_MARK_EN
    logic is_mark;
    logic mark_found_q, mark_found_d;

    wd_byte_match #(
        .WIDTH (WIDTH)
    ) u_mark_match (
        .data_i    (byte_buffer),
        .pattern_i (MARK_VAL),
        .match_o   (is_mark)
    );
`endif

    // Saturating increment: the count pins at all-ones rather than wrapping.
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_seen_d = gap_seen_q;
`ifdef WD_SYNC_MARK_EN
        mark_found_d = 1'b0;
`endif
        if (byte_valid) begin
            gap_seen_d = is_gap;
            unique case (state_q)
                StHunt: begin
                    if (is_gap) begin
                        cnt_d   = CNT_W'(1);
                        state_d = (MIN_GAP == 1) ? StLock : StGap;
                    end else begin
                        cnt_d = '0;
                    end
                end
                StGap: begin
                    if (is_gap) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= MinGapCnt) state_d = StLock;
                    end else begin
                        cnt_d   = '0;
                        state_d = StHunt;
                    end
                end
                StLock: begin
                    if (is_gap) begin
                        cnt_d = cnt_inc;
                    end else begin
                        cnt_d   = '0;
                        state_d = StHunt;
`ifdef WD_SYNC_MARK_EN
                        mark_found_d = is_mark;
`endif
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = StHunt;
                end
            endcase
        end
        locked_d = (state_d == StLock);
    end

    always_ff @(negedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StHunt;
            cnt_q      <= '0;
            gap_seen_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_seen_q <= gap_seen_d;
            locked_q   <= locked_d;
        end
    end

`ifdef WD_SYNC_MARK_EN
    always_ff @(negedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            mark_found_q <= 1'b0;
        end else begin
            mark_found_q <= mark_found_d;
        end
    end

    assign mark_found = mark_found_q;
`else
    assign mark_found = 1'b0;
`endif

    assign gap_seen  = gap_seen_q;
    assign locked    = locked_q;
    assign gap_count = cnt_q;

endmodule

// File: tb/tb_wd_sync_detector.sv
// Bench for wd_sync_detector: directed sync scenarios plus random bytes against a run-length model.
module tb_wd_sync_detector;

`ifdef WD_SYNC_MARK_EN
    localparam bit MarkEn = 1'b1;
`else
    localparam bit MarkEn = 1'b0;
`endif

    logic       clk_50 = 1'b0;
    logic       reset_n;
    logic       byte_valid;
    logic [7:0] byte_buffer;

    logic       gs0, lk0, mk0;
    logic [5:0] cnt0;
    logic       gs1, lk1, mk1;
    logic [5:0] cnt1;

    int tests = 0;
    int fails = 0;

    // Model: length of the current run of qualified gap bytes, per DUT.
    int run0, run1;
    bit gs_m, mk0_m, mk1_m;

    always #10 clk_50 = ~clk_50;

    wd_sync_detector dut (
        .clk_50      (clk_50),
        .reset_n     (reset_n),
        .byte_valid  (byte_valid),
        .byte_buffer (byte_buffer),
        .gap_seen    (gs0),
        .locked      (lk0),
        .mark_found  (mk0),
        .gap_count   (cnt0)
    );

    wd_sync_detector #(
        .MIN_GAP (1)
    ) dut_m1 (
        .clk_50      (clk_50),
        .reset_n     (reset_n),
        .byte_valid  (byte_valid),
        .byte_buffer (byte_buffer),
        .gap_seen    (gs1),
        .locked      (lk1),
        .mark_found  (mk1),
        .gap_count   (cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat63(input int n);
        return (n > 63) ? 63 : n;
    endfunction

    task automatic chk_all(input string tag);
        chk({tag, " gap_seen"},     32'(gs0),  32'(gs_m));
        chk({tag, " locked"},       32'(lk0),  32'(run0 >= 4));
        chk({tag, " mark_found"},   32'(mk0),  32'(mk0_m));
        chk({tag, " gap_count"},    32'(cnt0), 32'(sat63(run0)));
        chk({tag, " m1 gap_seen"},  32'(gs1),  32'(gs_m));
        chk({tag, " m1 locked"},    32'(lk1),  32'(run1 >= 1));
        chk({tag, " m1 mark_found"}, 32'(mk1), 32'(mk1_m));
        chk({tag, " m1 gap_count"}, 32'(cnt1), 32'(sat63(run1)));
    endtask

    task automatic model_reset();
        run0 = 0; run1 = 0; gs_m = 1'b0; mk0_m = 1'b0; mk1_m = 1'b0;
    endtask

    // Inputs change 5 ns after a falling edge; results are checked 5 ns after the next one.
    task automatic step(input logic v, input logic [7:0] b, input string tag);
        byte_valid  = v;
        byte_buffer = b;
        @(negedge clk_50);
        if (v) begin
            gs_m  = (b == 8'h4E);
            mk0_m = MarkEn && (run0 >= 4) && (b == 8'hA1);
            mk1_m = MarkEn && (run1 >= 1) && (b == 8'hA1);
            if (b == 8'h4E) begin
                run0++; run1++;
            end else begin
                run0 = 0; run1 = 0;
            end
        end else begin
            mk0_m = 1'b0; mk1_m = 1'b0;
        end
        #5;
        chk_all(tag);
    endtask

    task automatic do_reset();
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_reset");
        #2 reset_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        byte_valid  = 1'b0;
        byte_buffer = 8'h00;
        model_reset();
        #1 chk_all("reset_state");
        #5 reset_n = 1'b1;
        @(negedge clk_50);
        #5;

        // Four gap bytes lock the default instance on the fourth.
        for (int i = 0; i < 4; i++) step(1'b1, 8'h4E, "four_gaps");
        step(1'b0, 8'h00, "idle_hold");
        do_reset();

        // Broken run returns to hunt without ever locking.
        step(1'b1, 8'h4E, "broken_run");
        step(1'b1, 8'h4E, "broken_run");
        step(1'b1, 8'h4E, "broken_run");
        step(1'b1, 8'h00, "broken_run");
        do_reset();

        // Six gaps, then a mark; mark_found must drop after one clock.
        for (int i = 0; i < 6; i++) step(1'b1, 8'h4E, "gaps_then_mark");
        step(1'b1, 8'hA1, "mark");
        step(1'b0, 8'hA1, "mark_pulse_end");
        step(1'b1, 8'h4E, "after_mark");
        step(1'b1, 8'hA1, "mark_too_early");
        do_reset();

        // Long run saturates the count.
        for (int i = 0; i < 70; i++) step(1'b1, 8'h4E, "saturate");
        step(1'b0, 8'h4E, "saturate_hold");
        // Reset between edges while locked.
        do_reset();
        step(1'b1, 8'h4E, "restart_after_reset");

        // Unqualified cycles between bytes must not disturb either instance.
        step(1'b0, 8'h00, "valid_gap");
        step(1'b0, 8'hA1, "valid_gap");
        step(1'b1, 8'h4E, "valid_gap");
        do_reset();

        for (int i = 0; i < 400; i++) begin
            logic       v;
            logic [7:0] b;
            int         sel;
            v   = ($urandom_range(0, 3) != 0);
            sel = int'($urandom_range(0, 9));
            if (sel < 6)      b = 8'h4E;
            else if (sel < 8) b = 8'hA1;
            else              b = 8'($urandom);
            step(v, b, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wd_sync_detector.md
WD_SYNC_DETECTOR -- requirements
Module: wd_sync_detector

Interface
REQ-001 Parameter: WIDTH, default 8, width of the byte_buffer bus.
REQ-002 Parameter: GAP_VAL, default 8'h4E, gap byte value.
REQ-003 Parameter: MARK_VAL, default 8'hA1, address-mark byte value; SHALL differ from GAP_VAL.
REQ-004 Parameter: MIN_GAP, default 4, number of consecutive gap bytes required for lock; legal range 1 to 2^CNT_W-1.
REQ-005 Parameter: CNT_W, default 6, width of the gap_count output.
REQ-006 Port: clk_50, input, 1 bit, the single clock; all state updates occur on its falling edge.
REQ-007 Port: reset_n, input, 1 bit, asynchronous active-low reset.
REQ-008 Port: byte_valid, input, 1 bit, qualifies a new byte on byte_buffer for exactly one clock.
REQ-009 Port: byte_buffer, input, WIDTH bits, deserialised MFM byte.
REQ-010 Port: gap_seen, output, 1 bit, registered: last qualified byte equalled GAP_VAL.
REQ-011 Port: locked, output, 1 bit, high while the FSM is in LOCK.
REQ-012 Port: mark_found, output, 1 bit, one-clock pulse on a mark following a valid gap run.
REQ-013 Port: gap_count, output, CNT_W bits, current consecutive-gap count.

Function
REQ-014 FSM states: HUNT, GAP, LOCK; only qualified bytes (byte_valid=1) advance state; with byte_valid=0, state, gap_count and gap_seen SHALL hold, and mark_found SHALL be 0.
REQ-015 HUNT: gap byte -> gap_count=1, next state LOCK if MIN_GAP==1, else GAP; any other byte -> stay, gap_count=0.
REQ-016 GAP: gap byte -> gap_count+1, next state LOCK when the new count >= MIN_GAP; any other byte -> HUNT, gap_count=0.
REQ-017 LOCK: gap byte -> stay, gap_count increments; MARK_VAL -> mark_found=1 for one clock, HUNT, gap_count=0; any other byte -> HUNT, gap_count=0.
REQ-018 gap_count SHALL saturate at 2^CNT_W-1, never wrap.
REQ-019 All outputs SHALL be registered, with one-clock latency from the qualified byte.
REQ-020 A MARK_VAL byte in HUNT or GAP SHALL NOT pulse mark_found, and SHALL return the FSM to HUNT.

Reset
REQ-021 reset_n low SHALL immediately force the following, regardless of the clock: state=HUNT, gap_count=0, gap_seen=0, locked=0, mark_found=0.
REQ-022 Reset asserted mid-run SHALL discard the run; after release, counting restarts from zero.

Configuration
REQ-023 Macro WD_SYNC_MARK_EN defined: mark detection per REQ-017.
REQ-024 Macro WD_SYNC_MARK_EN undefined: mark_found tied to 0; in LOCK, any non-gap byte (including MARK_VAL) -> HUNT.

Structure
REQ-025 Package wd_mfm_pkg SHALL hold the FSM state encoding and the default GAP and MARK byte constants.
REQ-026 Sub-module wd_byte_match SHALL perform the registered-free WIDTH-bit equality compare; it SHALL be instantiated twice, once for gap and once for mark.

Verification
REQ-027 Bench SHALL cover: four 8'h4E bytes with defaults -> locked=1 after the 4th byte, gap_count=4.
REQ-028 Bench SHALL cover: 4E 4E 4E 00 -> HUNT, gap_count=0, locked never asserted.
REQ-029 Bench SHALL cover: six 8'h4E bytes then 8'hA1 -> mark_found pulses exactly one clock; locked=0 and gap_count=0 afterwards (with WD_SYNC_MARK_EN); without the macro, mark_found stays 0.
REQ-030 Bench SHALL cover: 70 consecutive 8'h4E bytes -> gap_count holds at 63.
REQ-031 Bench SHALL cover: reset_n pulled low between clock edges while locked -> all outputs 0 before the next edge.
REQ-032 Bench SHALL cover: MIN_GAP=1 with one 8'h4E byte -> locked=1, and gaps in byte_valid hold state unchanged.
